// File: rtl/add_tree_pass_ctrl.sv
// add_tree_pass_ctrl: multi-pass accumulation controller for the 32-input adder tree.
// Keeps a D-entry partial-sum buffer (one entry per pixel), accumulates each
// 32-channel pass into it and streams final per-pixel sums on the last pass.
// Optional feature macro: ACC_SAT_EN -- signed saturation on every buffer/output add.
module add_tree_pass_ctrl #(
    parameter int unsigned D          = 220,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PASS_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PASS_W-1:0]     num_pass,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned       PIX_W    = (D > 1) ? $clog2(D) : 1;
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(D - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic [PASS_W-1:0]       pass_q, pass_d;
    logic [PASS_W-1:0]       npass_q, npass_d;
    logic [DATA_WIDTH-1:0]   pxl_out_q, pxl_out_d;
    logic                    valid_out_q, valid_out_d;

    logic [DATA_WIDTH-1:0]   mem_q [D];
    logic [DATA_WIDTH-1:0]   mem_rd;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;

    // Two's complement add; clamps to the signed range when saturation is built in.
    function automatic logic [DATA_WIDTH-1:0] acc_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] s;
        s = a + b;
`ifdef ACC_SAT_EN
        if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
            s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    assign mem_rd    = mem_q[pix_q];
    assign pxl_out   = pxl_out_q;
    assign valid_out = valid_out_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

    // Next-state, counter and datapath decode for the current beat.
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        pass_d      = pass_q;
        npass_d     = npass_q;
        pxl_out_d   = pxl_out_q;
        valid_out_d = 1'b0;
        wr_en       = 1'b0;
        wr_data     = pxl_in;
        case (state_q)
            IDLE: begin
                if (start) begin
                    npass_d = (num_pass == '0) ? PASS_W'(1) : num_pass;
                    pix_d   = '0;
                    pass_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (valid_in) begin
                    if (npass_q == PASS_W'(1)) begin
                        pxl_out_d   = pxl_in;
                        valid_out_d = 1'b1;
                    end else if (pass_q == '0) begin
                        wr_en   = 1'b1;
                        wr_data = pxl_in;
                    end else if (pass_q == npass_q - PASS_W'(1)) begin
                        pxl_out_d   = acc_add(mem_rd, pxl_in);
                        valid_out_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_data = acc_add(mem_rd, pxl_in);
                    end
                    if (pix_q == PIX_LAST) begin
                        pix_d  = '0;
                        pass_d = pass_q + PASS_W'(1);
                        if (pass_q == npass_q - PASS_W'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            pass_q      <= '0;
            npass_q     <= PASS_W'(1);
            pxl_out_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            pass_q      <= pass_d;
            npass_q     <= npass_d;
            pxl_out_q   <= pxl_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Partial-sum buffer; never cleared, pass 0 overwrites every entry.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_q[pix_q] <= wr_data;
        end
    end

endmodule
